// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the prefetch buffer entry type
package rv32_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_if.sv
// if_prefetch_if: instruction-memory request/response bus between prefetcher and memory
interface if_prefetch_if;
   import rv32_pkg::*;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );
endinterface

// File: rtl/pf_fifo.sv
// pf_fifo: DEPTH-entry {pc,instr} synchronous FIFO with occupancy count and flush
module pf_fifo import rv32_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           din,
   input  logic                   pop,
   output fetch_entry_t           dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic wr, rd;
   always_comb begin
      rd = rst && !flush && pop && count != '0;
      wr = rst && !flush && push && (count != CW'(DEPTH) || rd);
      dout = mem[rd_ptr];
   end
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= din;
   always_ff @(posedge clk)
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr) - CW'(rd);
      end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetcher with credit-bounded requests, buffer and redirect discard
module if_prefetch import rv32_pkg::*; #(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   if_prefetch_if.master   imem,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr_fetch,
   output logic [XLEN-1:0] pc
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [XLEN-1:0] fetch_pc, rsp_pc, last_pc, new_pc;
   logic [CW-1:0] count, outs, disc, inflight;
   logic fire, rsp, push, pop;
   fetch_entry_t head, wdata;
   always_comb begin
      imem.imem_req_valid = rst && (({1'b0, count} + {1'b0, outs}) < (CW + 1)'(DEPTH));
      imem.imem_req_addr = fetch_pc;
      fire = imem.imem_req_valid && imem.imem_req_ready;
      rsp = imem.imem_rsp_valid;
      inflight = outs + CW'(fire) - CW'(rsp);
      new_pc = redirect_pc & ~32'h3;
      push = rsp && disc == '0 && !redirect;
      wdata = '{pc: rsp_pc, instr: imem.imem_rsp_data};
      instr_valid = count != '0;
      pop = instr_valid && !stall && !redirect;
      instr_fetch = instr_valid ? head.instr : NOP_INSTR;
      pc = instr_valid ? head.pc : last_pc;
   end
   pf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .din   (wdata),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );
   // rsp_pc tracks the address of the next kept response, so entries need no address queue
   always_ff @(posedge clk)
      if (!rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc <= RESET_PC;
         last_pc <= RESET_PC;
         outs <= '0;
         disc <= '0;
      end else begin
         outs <= inflight;
         if (instr_valid) last_pc <= head.pc;
         if (redirect) begin
            fetch_pc <= new_pc;
            rsp_pc <= new_pc;
            disc <= inflight;
         end else begin
            if (fire) fetch_pc <= fetch_pc + PC_STEP;
            if (push) rsp_pc <= rsp_pc + PC_STEP;
            if (rsp && disc != '0) disc <= disc - CW'(1);
         end
      end
endmodule
